// File: rtl/kme_ib_arbiter.sv
// kme_ib_arbiter: frame-atomic round-robin arbiter that merges N_REQ AXI-Stream
// requesters onto the single KME inbound stream. A requester is locked from its
// first beat through its tlast beat. The first beat's tuser is checked for SoT.
module kme_ib_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 64,
  parameter int UW    = 8,
  parameter int SW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_tvalid,
  input  logic [N_REQ-1:0]     req_tlast,
  input  logic [N_REQ*DW-1:0]  req_tdata,
  input  logic [N_REQ*UW-1:0]  req_tuser,
  input  logic [N_REQ*SW-1:0]  req_tstrb,
  output logic [N_REQ-1:0]     req_tready,
  output logic                 kme_ib_tvalid,
  output logic                 kme_ib_tlast,
  output logic [DW-1:0]        kme_ib_tdata,
  output logic [UW-1:0]        kme_ib_tuser,
  output logic [SW-1:0]        kme_ib_tstrb,
  input  logic                 kme_ib_tready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic [15:0]          frame_cnt,
  output logic                 sot_err
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

  localparam logic [UW-1:0] SOT_USER = UW'(1);

  state_e      state_q, state_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  grant_q, grant_d;
  logic        busy_q, busy_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        sot_err_q, sot_err_d;
  logic        first_q, first_d;

  logic        pick_found_s;
  logic [2:0]  pick_idx_s;
  logic        sel_tvalid_s;
  logic        sel_tlast_s;
  logic        xfer_s;
  logic        locked_s;

  // Returns vec[idx]; idx values outside the vector read as 0.
  function automatic logic bit_at(input logic [N_REQ-1:0] vec, input logic [2:0] idx);
    logic r;
    r = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      r = (idx == 3'(j)) ? vec[j] : r;
    end
    return r;
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [3:0] cand;
    pick_found_s = 1'b0;
    pick_idx_s   = 3'd0;
    cand         = 4'd0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + 4'(k);
      if (cand >= 4'(N_REQ)) begin
        cand = cand - 4'(N_REQ);
      end else begin
        cand = cand;
      end
      if (!pick_found_s && bit_at(req_tvalid, cand[2:0])) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand[2:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Steer the locked requester onto the KME stream; nothing passes in IDLE or reset.
  always_comb begin
    locked_s      = (state_q == ST_LOCKED) && !rst;
    sel_tvalid_s  = bit_at(req_tvalid, grant_q);
    sel_tlast_s   = bit_at(req_tlast, grant_q);
    kme_ib_tdata  = '0;
    kme_ib_tuser  = '0;
    kme_ib_tstrb  = '0;
    req_tready    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        kme_ib_tdata  = req_tdata[i*DW +: DW];
        kme_ib_tuser  = req_tuser[i*UW +: UW];
        kme_ib_tstrb  = req_tstrb[i*SW +: SW];
        req_tready[i] = locked_s && kme_ib_tready;
      end else begin
        req_tready[i] = 1'b0;
      end
    end
    kme_ib_tvalid = locked_s && sel_tvalid_s;
    kme_ib_tlast  = sel_tlast_s;
    xfer_s        = kme_ib_tvalid && kme_ib_tready;
  end

  // Next-state logic: lock on a pick, release after the tlast beat transfers.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
    sot_err_d   = 1'b0;
    first_d     = first_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d = ST_LOCKED;
          grant_d = pick_idx_s;
          busy_d  = 1'b1;
          first_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (xfer_s) begin
          first_d   = 1'b0;
          sot_err_d = first_q && (kme_ib_tuser != SOT_USER);
          if (sel_tlast_s) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
            grant_d  = 3'd0;
            busy_d   = 1'b0;
            if (frame_cnt_q != 16'hFFFF) begin
              frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
              frame_cnt_d = frame_cnt_q;
            end
          end else begin
            state_d = ST_LOCKED;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        grant_d  = 3'd0;
        busy_d   = 1'b0;
        first_d  = 1'b0;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 3'd0;
      grant_q     <= 3'd0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
      sot_err_q   <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      sot_err_q   <= sot_err_d;
      first_q     <= first_d;
    end
  end

  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
  assign sot_err   = sot_err_q;

endmodule

// File: doc/kme_ib_arbiter.md
KME_IB_ARBITER -- requirements
Module: kme_ib_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of inbound requester ports, range 2..8.
REQ-002 The block SHALL have parameter DW, default 64: tdata width.
REQ-003 The block SHALL have parameter UW, default 8: tuser width.
REQ-004 The block SHALL have parameter SW, default 8: tstrb width.
REQ-005 The block SHALL have port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 The block SHALL have port req_tvalid, input, N_REQ: per-requester valid.
REQ-008 The block SHALL have port req_tlast, input, N_REQ: per-requester last beat of frame.
REQ-009 The block SHALL have port req_tdata, input, N_REQ*DW: packed per-requester data, requester i at [i*DW +: DW].
REQ-010 The block SHALL have port req_tuser, input, N_REQ*UW: packed tuser, same packing.
REQ-011 The block SHALL have port req_tstrb, input, N_REQ*SW: packed tstrb, same packing.
REQ-012 The block SHALL have port req_tready, output, N_REQ: per-requester ready.
REQ-013 The block SHALL have ports kme_ib_tvalid, kme_ib_tlast, kme_ib_tdata, kme_ib_tuser and kme_ib_tstrb, outputs of width 1, 1, DW, UW and SW: the stream to the KME inbound port.
REQ-014 The block SHALL have port kme_ib_tready, input, 1: ready from KME.
REQ-015 The block SHALL have port grant_id, output, 3: index of the locked requester; 0 when idle.
REQ-016 The block SHALL have port busy, output, 1: asserted while a frame is locked.
REQ-017 The block SHALL have port frame_cnt, output, 16: count of completed frames, saturating at 16'hFFFF.
REQ-018 The block SHALL have port sot_err, output, 1: one-cycle pulse when the first accepted beat of a frame has tuser != 8'h01 (SoT).

Function
REQ-019 The state machine SHALL have two states: IDLE and LOCKED.
REQ-020 In IDLE with any req_tvalid bit set, the block SHALL select the first set bit at or after rr_ptr, modulo N_REQ; it SHALL register that index into grant_id, set busy and enter LOCKED on the next edge.
- Grant latency is 1 cycle; no beat is forwarded in IDLE.
REQ-021 In IDLE, kme_ib_tvalid SHALL be 0 and all req_tready bits SHALL be 0.
REQ-022 In LOCKED, kme_ib_* SHALL be driven combinationally from requester grant_id, req_tready[grant_id] SHALL equal kme_ib_tready, and all other req_tready bits SHALL be 0.
REQ-023 A beat SHALL count as transferred only when kme_ib_tvalid and kme_ib_tready are both 1; this is the standard valid/ready handshake, and no beat is dropped or duplicated.
REQ-024 A transferred beat with tlast=1 SHALL, on the next edge:
- return the block to IDLE;
- set rr_ptr to (grant_id+1) mod N_REQ;
- clear busy and grant_id;
- increment frame_cnt, saturating.
REQ-025 The grant SHALL be frame-atomic: other requesters SHALL NOT be served mid-frame, regardless of their tvalid, and a locked requester dropping tvalid mid-frame SHALL hold the lock.
REQ-026 A tracking flag SHALL be set at LOCKED entry and cleared by the first transferred beat; sot_err SHALL pulse in the cycle after that beat if its tuser != 8'h01.
REQ-027 A single-beat frame (first beat carries tlast) SHALL be legal: SoT check and frame completion both apply to that beat.
REQ-028 Back-to-back frames SHALL incur exactly one IDLE cycle between the tlast beat and the next frame's first beat.
REQ-029 The rr_ptr arithmetic SHALL wrap: when grant_id = N_REQ-1, rr_ptr becomes 0.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL enter IDLE and clear rr_ptr, grant_id, busy, frame_cnt, sot_err and the tracking flag to 0.
REQ-031 While in reset, kme_ib_tvalid and req_tready SHALL be 0.
REQ-032 Reset asserted mid-frame SHALL abandon the lock at once, with no tlast emitted; the next frame after reset SHALL be arbitrated from rr_ptr=0.

Verification
REQ-033 Single requester: req 2 sends 3 beats (SoT, mid, EoT with tlast), kme_ib_tready=1 -> first beat on kme_ib one cycle after tvalid; grant_id=2; frame_cnt=1; sot_err=0.
REQ-034 Fairness: all 4 requesters hold continuous 2-beat frames -> grant order 0,1,2,3,0; one IDLE cycle between frames.
REQ-035 Frame atomicity: req 1 locked, kme_ib_tready toggles 1/0, req 1 drops tvalid for 3 cycles, req 0 asserts tvalid -> req 1 completes its frame before req 0 is granted; req_tready[0] stays 0 throughout.
REQ-036 SoT error: first beat tuser=8'h03 -> sot_err pulses for exactly one cycle; the frame still completes and frame_cnt increments.
REQ-037 Reset mid-frame: rst asserted after beat 2 of 4 -> next cycle busy=0, kme_ib_tvalid=0, frame_cnt=0; requester 3 is arbitrated first from rr_ptr=0 after release.
REQ-038 Saturation: frame_cnt preloaded by forcing 65535 completions -> frame_cnt holds 16'hFFFF on further frames.
